// File: rtl/mem_access_unit.sv
// M-stage data memory initiator: request decode, address exceptions,
// load extension/merge and the M/W load-result register.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [3:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_rt,
    input  logic [4:0]  m_dst,
    input  logic        stall,
    input  logic        flush,
    output logic        MemWrite,
    output logic [1:0]  SwMode,
    output logic [1:0]  AddrLow2,
    output logic [3:0]  ByteEnable,
    output logic [10:0] DataAddr,
    output logic [31:0] WriteData,
    input  logic [31:0] mem_rdata,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] exc_badvaddr,
    output logic        w_regwrite,
    output logic [4:0]  w_dst,
    output logic [31:0] w_wdata,
    output logic [31:0] store_count
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_LWL = 4'd6;
    localparam logic [3:0] OP_LWR = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SWL = 4'd11;
    localparam logic [3:0] OP_SWR = 4'd12;

    logic        isLoad;
    logic        isStore;
    logic        isByte;
    logic        isHalf;
    logic        isWord;
    logic        addrErr;
    logic [1:0]  low2;
    logic [31:0] rd;
    logic [31:0] rt;
    logic [31:0] loadResult;

    assign low2      = m_addr[1:0];
    assign rd        = mem_rdata;
    assign rt        = m_rt;
    assign AddrLow2  = low2;
    assign DataAddr  = m_addr[12:2];
    assign WriteData = m_rt;

    always_comb begin
        isLoad  = (m_op >= OP_LB) && (m_op <= OP_LWR);
        isStore = (m_op >= OP_SB) && (m_op <= OP_SWR);
        isByte  = (m_op == OP_LB) || (m_op == OP_LBU) || (m_op == OP_SB);
        isHalf  = (m_op == OP_LH) || (m_op == OP_LHU) || (m_op == OP_SH);
        isWord  = (m_op == OP_LW) || (m_op == OP_SW);
        addrErr = (m_addr[31:13] != 19'd0)
                || (isHalf && low2[0])
                || (isWord && (low2 != 2'b00));
    end

    always_comb begin
        ByteEnable = 4'b0000;
        unique case (1'b1)
            isByte:  ByteEnable = 4'b0001 << low2;
            isHalf:  ByteEnable = low2[1] ? 4'b1100 : 4'b0011;
            isWord:  ByteEnable = 4'b1111;
            default: ByteEnable = 4'b0000;
        endcase
    end

    always_comb begin
        SwMode = 2'b00;
        if (m_op == OP_SWL)
            SwMode = 2'b01;
        else if (m_op == OP_SWR)
            SwMode = 2'b10;
    end

    assign exc_adel     = m_valid & isLoad & addrErr;
    assign exc_ades     = m_valid & isStore & addrErr;
    assign exc_badvaddr = (exc_adel | exc_ades) ? m_addr : 32'd0;
    assign MemWrite     = m_valid & isStore & ~exc_ades & ~stall & ~reset;

    // Memory already returns byte/half lanes right-justified.
    always_comb begin
        loadResult = 32'd0;
        case (m_op)
            OP_LB:  loadResult = {{24{rd[7]}}, rd[7:0]};
            OP_LBU: loadResult = {24'd0, rd[7:0]};
            OP_LH:  loadResult = {{16{rd[15]}}, rd[15:0]};
            OP_LHU: loadResult = {16'd0, rd[15:0]};
            OP_LW:  loadResult = rd;
            OP_LWL: begin
                case (low2)
                    2'd0:    loadResult = {rd[7:0], rt[23:0]};
                    2'd1:    loadResult = {rd[15:0], rt[15:0]};
                    2'd2:    loadResult = {rd[23:0], rt[7:0]};
                    default: loadResult = rd;
                endcase
            end
            OP_LWR: begin
                case (low2)
                    2'd0:    loadResult = rd;
                    2'd1:    loadResult = {rt[31:24], rd[31:8]};
                    2'd2:    loadResult = {rt[31:16], rd[31:16]};
                    default: loadResult = {rt[31:8], rd[31:24]};
                endcase
            end
            default: loadResult = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_regwrite  <= 1'b0;
            w_dst       <= 5'd0;
            w_wdata     <= 32'd0;
            store_count <= 32'd0;
        end else begin
            if (MemWrite)
                store_count <= store_count + 32'd1;
            if (flush) begin
                w_regwrite <= 1'b0;
                w_dst      <= 5'd0;
                w_wdata    <= 32'd0;
            end else if (!stall) begin
                w_regwrite <= m_valid & isLoad & ~exc_adel & (m_dst != 5'd0);
                w_dst      <= m_dst;
                w_wdata    <= loadResult;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table,
// hand sequences for stall/flush/reset, and a randomized model run.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [3:0]  m_op;
    logic [31:0] m_addr;
    logic [31:0] m_rt;
    logic [4:0]  m_dst;
    logic        stall;
    logic        flush;
    logic        MemWrite;
    logic [1:0]  SwMode;
    logic [1:0]  AddrLow2;
    logic [3:0]  ByteEnable;
    logic [10:0] DataAddr;
    logic [31:0] WriteData;
    logic [31:0] mem_rdata;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] exc_badvaddr;
    logic        w_regwrite;
    logic [4:0]  w_dst;
    logic [31:0] w_wdata;
    logic [31:0] store_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op),
        .m_addr(m_addr), .m_rt(m_rt), .m_dst(m_dst), .stall(stall),
        .flush(flush), .MemWrite(MemWrite), .SwMode(SwMode),
        .AddrLow2(AddrLow2), .ByteEnable(ByteEnable), .DataAddr(DataAddr),
        .WriteData(WriteData), .mem_rdata(mem_rdata), .exc_adel(exc_adel),
        .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr),
        .w_regwrite(w_regwrite), .w_dst(w_dst), .w_wdata(w_wdata),
        .store_count(store_count)
    );

    // Behavioural 8 KB memory: lane select on read, lane merge on write.
    logic [31:0] mem [0:2047];

    always_comb begin
        logic [31:0] w;
        w = mem[DataAddr];
        case (ByteEnable)
            4'b0001: mem_rdata = {24'd0, w[7:0]};
            4'b0010: mem_rdata = {24'd0, w[15:8]};
            4'b0100: mem_rdata = {24'd0, w[23:16]};
            4'b1000: mem_rdata = {24'd0, w[31:24]};
            4'b0011: mem_rdata = {16'd0, w[15:0]};
            4'b1100: mem_rdata = {16'd0, w[31:16]};
            default: mem_rdata = w;
        endcase
    end

    always @(posedge clk) begin
        if (MemWrite) begin
            logic [31:0] w;
            int k;
            w = mem[DataAddr];
            k = int'(AddrLow2);
            if (SwMode == 2'b01) begin
                for (int i = 0; i <= k; i++)
                    w[8*i +: 8] = WriteData[8*(3-k+i) +: 8];
            end else if (SwMode == 2'b10) begin
                for (int i = k; i < 4; i++)
                    w[8*i +: 8] = WriteData[8*(i-k) +: 8];
            end else begin
                case (ByteEnable)
                    4'b0001: w[7:0]   = WriteData[7:0];
                    4'b0010: w[15:8]  = WriteData[7:0];
                    4'b0100: w[23:16] = WriteData[7:0];
                    4'b1000: w[31:24] = WriteData[7:0];
                    4'b0011: w[15:0]  = WriteData[15:0];
                    4'b1100: w[31:16] = WriteData[15:0];
                    4'b1111: w        = WriteData;
                    default: ;
                endcase
            end
            mem[DataAddr] <= w;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference semantics from the architectural description.
    function automatic bit refIsLoad(input int op);
        return op >= 1 && op <= 7;
    endfunction

    function automatic bit refIsStore(input int op);
        return op >= 8 && op <= 12;
    endfunction

    function automatic bit refAddrErr(input int op, input logic [31:0] a);
        if (a >= 32'h2000) return 1'b1;
        if ((op == 3 || op == 4 || op == 9) && (a % 2 != 0)) return 1'b1;
        if ((op == 5 || op == 10) && (a % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] refBe(input int op, input logic [31:0] a);
        int k;
        k = int'(a % 4);
        if (op == 1 || op == 2 || op == 8) return 4'(1 << k);
        if (op == 3 || op == 4 || op == 9) return (k >= 2) ? 4'hC : 4'h3;
        if (op == 5 || op == 10) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] refLoad(input int op,
            input logic [31:0] a, input logic [31:0] rt,
            input logic [31:0] word);
        int k;
        logic [31:0] v;
        logic [31:0] mask;
        k = int'(a % 4);
        v = 32'd0;
        case (op)
            1, 2: begin
                v = (word >> (8 * k)) & 32'hFF;
                if (op == 1 && v[7]) v = v | 32'hFFFFFF00;
            end
            3, 4: begin
                v = (word >> (8 * k)) & 32'hFFFF;
                if (op == 3 && v[15]) v = v | 32'hFFFF0000;
            end
            5: v = word;
            6: begin
                mask = (32'd1 << (8 * (3 - k))) - 32'd1;
                v = (word << (8 * (3 - k))) | (rt & mask);
            end
            7: begin
                mask = 32'hFFFFFFFF >> (8 * k);
                v = (word >> (8 * k)) | (rt & ~mask);
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [4:0]  dst;
        logic [3:0]  eBe;
        logic [1:0]  eSw;
        logic        eMw;
        logic        eAdel;
        logic        eAdes;
        logic        eRw;
        logic [31:0] eWd;
    } vec_t;

    vec_t vecs[$];

    task automatic setIn(input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] rt,
                         input logic [4:0] d, input logic st,
                         input logic fl);
        m_valid = v; m_op = op; m_addr = a; m_rt = rt;
        m_dst = d; stall = st; flush = fl;
    endtask

    logic        eRw;
    logic [4:0]  eDst;
    logic [31:0] eWd;
    logic [31:0] eCnt;

    initial begin
        reset = 1'b1;
        setIn(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(w_regwrite), 32'd0);
        chk("rst_dst", 32'(w_dst), 32'd0);
        chk("rst_wdata", w_wdata, 32'd0);
        chk("rst_count", store_count, 32'd0);
        reset = 1'b0;

        //           op     addr            rt            dst   be    sw   mw adl ads rw wd
        vecs.push_back('{4'd10, 32'h10, 32'h88776655, 5'd0, 4'hF, 2'b00, 1, 0, 0, 0, 32'h0});
        vecs.push_back('{4'd1,  32'h13, 32'h0,        5'd3, 4'h8, 2'b00, 0, 0, 0, 1, 32'hFFFFFF88});
        vecs.push_back('{4'd2,  32'h13, 32'h0,        5'd3, 4'h8, 2'b00, 0, 0, 0, 1, 32'h00000088});
        vecs.push_back('{4'd3,  32'h10, 32'h0,        5'd3, 4'h3, 2'b00, 0, 0, 0, 1, 32'h00006655});
        vecs.push_back('{4'd4,  32'h12, 32'h0,        5'd3, 4'hC, 2'b00, 0, 0, 0, 1, 32'h00008877});
        vecs.push_back('{4'd5,  32'h10, 32'h0,        5'd5, 4'hF, 2'b00, 0, 0, 0, 1, 32'h88776655});
        vecs.push_back('{4'd5,  32'h10, 32'h0,        5'd0, 4'hF, 2'b00, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{4'd6,  32'h11, 32'hAABBCCDD, 5'd3, 4'h0, 2'b00, 0, 0, 0, 1, 32'h6655CCDD});
        vecs.push_back('{4'd7,  32'h12, 32'hAABBCCDD, 5'd3, 4'h0, 2'b00, 0, 0, 0, 1, 32'hAABB8877});
        vecs.push_back('{4'd6,  32'h13, 32'hAABBCCDD, 5'd3, 4'h0, 2'b00, 0, 0, 0, 1, 32'h88776655});
        vecs.push_back('{4'd9,  32'h16, 32'h1234ABCD, 5'd0, 4'hC, 2'b00, 1, 0, 0, 0, 32'h0});
        vecs.push_back('{4'd12, 32'h11, 32'h11223344, 5'd0, 4'h0, 2'b10, 1, 0, 0, 0, 32'h0});
        vecs.push_back('{4'd5,  32'h0E, 32'h0,        5'd3, 4'hF, 2'b00, 0, 1, 0, 0, 32'h0});
        vecs.push_back('{4'd10, 32'h2000, 32'h5,      5'd0, 4'hF, 2'b00, 0, 0, 1, 0, 32'h0});
        vecs.push_back('{4'd6,  32'h2003, 32'h0,      5'd3, 4'h0, 2'b00, 0, 1, 0, 0, 32'h0});

        foreach (vecs[i]) begin
            setIn(1'b1, vecs[i].op, vecs[i].addr, vecs[i].rt,
                  vecs[i].dst, 1'b0, 1'b0);
            #2;
            chk($sformatf("v%0d_be", i), 32'(ByteEnable), 32'(vecs[i].eBe));
            chk($sformatf("v%0d_swmode", i), 32'(SwMode), 32'(vecs[i].eSw));
            chk($sformatf("v%0d_memwrite", i), 32'(MemWrite), 32'(vecs[i].eMw));
            chk($sformatf("v%0d_adel", i), 32'(exc_adel), 32'(vecs[i].eAdel));
            chk($sformatf("v%0d_ades", i), 32'(exc_ades), 32'(vecs[i].eAdes));
            chk($sformatf("v%0d_badva", i), exc_badvaddr,
                (vecs[i].eAdel || vecs[i].eAdes) ? vecs[i].addr : 32'd0);
            chk($sformatf("v%0d_daddr", i), 32'(DataAddr), 32'(vecs[i].addr[12:2]));
            chk($sformatf("v%0d_low2", i), 32'(AddrLow2), 32'(vecs[i].addr[1:0]));
            chk($sformatf("v%0d_wdata_out", i), WriteData, vecs[i].rt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_w_regwrite", i), 32'(w_regwrite), 32'(vecs[i].eRw));
            if (vecs[i].eRw)
                chk($sformatf("v%0d_w_wdata", i), w_wdata, vecs[i].eWd);
        end
        chk("table_count", store_count, 32'd3);

        // Stall: W frozen, store commits once on release.
        setIn(1'b1, 4'd5, 32'h10, 32'h0, 5'd6, 1'b0, 1'b0);
        eWd = refLoad(5, 32'h10, 32'h0, mem[4]);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            setIn(1'b1, 4'd8, 32'h20, 32'h5A, 5'd0, 1'b1, 1'b0);
            #2;
            chk("stall_memwrite", 32'(MemWrite), 32'd0);
            @(posedge clk);
            #1;
            chk("stall_regwrite", 32'(w_regwrite), 32'd1);
            chk("stall_dst", 32'(w_dst), 32'd6);
            chk("stall_wdata", w_wdata, eWd);
            chk("stall_count", store_count, 32'd3);
        end
        stall = 1'b0;
        #2;
        chk("release_memwrite", 32'(MemWrite), 32'd1);
        @(posedge clk);
        #1;
        chk("release_count", store_count, 32'd4);
        chk("release_regwrite", 32'(w_regwrite), 32'd0);
        chk("sb_written", mem[8] & 32'hFF, 32'h5A);

        // Flush beats stall.
        setIn(1'b1, 4'd5, 32'h10, 32'h0, 5'd7, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("flush_regwrite", 32'(w_regwrite), 32'd0);
        chk("flush_dst", 32'(w_dst), 32'd0);
        chk("flush_wdata", w_wdata, 32'd0);

        // Reset mid-sequence with a store in M.
        setIn(1'b1, 4'd5, 32'h10, 32'h0, 5'd9, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_regwrite", 32'(w_regwrite), 32'd1);
        setIn(1'b1, 4'd8, 32'h24, 32'h77, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rst_regwrite", 32'(w_regwrite), 32'd0);
        chk("mid_rst_dst", 32'(w_dst), 32'd0);
        chk("mid_rst_wdata", w_wdata, 32'd0);
        chk("mid_rst_count", store_count, 32'd0);
        reset = 1'b0;

        // Randomized run against the reference model.
        eRw = 1'b0; eDst = 5'd0; eWd = 32'd0; eCnt = 32'd0;
        for (int n = 0; n < 400; n++) begin
            int op;
            logic [31:0] a;
            logic [31:0] rt;
            logic v, st, fl, err, eMw, eAdel, eAdes;
            logic [4:0] d;
            op = int'($urandom_range(0, 15));
            a  = $urandom;
            if ($urandom_range(0, 7) != 0) a = a & 32'h1FFF;
            rt = $urandom;
            d  = 5'($urandom_range(0, 31));
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 9) == 0);
            setIn(v, 4'(op), a, rt, d, st, fl);
            #2;
            err   = refAddrErr(op, a);
            eAdel = v && refIsLoad(op) && err;
            eAdes = v && refIsStore(op) && err;
            eMw   = v && refIsStore(op) && !eAdes && !st;
            chk("rnd_be", 32'(ByteEnable), 32'(refBe(op, a)));
            chk("rnd_swmode", 32'(SwMode),
                (op == 11) ? 32'd1 : (op == 12) ? 32'd2 : 32'd0);
            chk("rnd_memwrite", 32'(MemWrite), 32'(eMw));
            chk("rnd_adel", 32'(exc_adel), 32'(eAdel));
            chk("rnd_ades", 32'(exc_ades), 32'(eAdes));
            chk("rnd_badva", exc_badvaddr, (eAdel || eAdes) ? a : 32'd0);
            chk("rnd_daddr", 32'(DataAddr), (a / 4) % 2048);
            chk("rnd_low2", 32'(AddrLow2), a % 4);
            chk("rnd_wdata_out", WriteData, rt);
            if (fl) begin
                eRw = 1'b0; eDst = 5'd0; eWd = 32'd0;
            end else if (!st) begin
                eRw  = v && refIsLoad(op) && !eAdel && (d != 0);
                eDst = d;
                eWd  = refLoad(op, a, rt, mem[(a / 4) % 2048]);
            end
            if (eMw) eCnt = eCnt + 32'd1;
            @(posedge clk);
            #1;
            chk("rnd_w_regwrite", 32'(w_regwrite), 32'(eRw));
            chk("rnd_w_dst", 32'(w_dst), 32'(eDst));
            if (eRw) chk("rnd_w_wdata", w_wdata, eWd);
            chk("rnd_count", store_count, eCnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Initiator side of the 8 KB data memory in the pipelined CPU; sits in the M stage, between the ALU result/forwarded rt and the data memory, and owns the M/W load-result register.
- Decodes each M-stage load or store into the memory's request signals: byte enables, SwMode, AddrLow2, word address and write data.
- Detects address exceptions on loads and stores.
- Sign/zero-extends or merges the returned read data (including lwl/lwr) and registers the result toward the W stage.

## Interface
- No parameters; memory size is fixed at 8 KB (word address [12:2]).
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  1  valid instruction in M
- m_op  in  4  0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwl, 7 lwr, 8 sb, 9 sh, 10 sw, 11 swl, 12 swr; 13–15 treated as none
- m_addr  in  32  effective address (ALUOutM)
- m_rt  in  32  forwarded rt: store data, and the old value for the lwl/lwr merge
- m_dst  in  5  load destination register
- stall  in  1  freeze M and W this cycle
- flush  in  1  insert a bubble into W
- MemWrite  out  1  memory write strobe
- SwMode  out  2  00 normal, 01 swl, 10 swr
- AddrLow2  out  2  m_addr[1:0]
- ByteEnable  out  4  lane select
- DataAddr  out  11  m_addr[12:2]
- WriteData  out  32  store data
- mem_rdata  in  32  memory ReadData (combinational)
- exc_adel / exc_ades  out  1  load / store address error (combinational, M stage)
- exc_badvaddr  out  32  m_addr while either exception is high, else 0
- w_regwrite  out  1  registered W-stage write enable
- w_dst  out  5  registered W-stage destination
- w_wdata  out  32  registered W-stage load result
- store_count  out  32  count of committed stores

## Operation
- **Request decode (combinational):**
  - DataAddr = m_addr[12:2]; AddrLow2 = m_addr[1:0].
- **ByteEnable per op:**
  - lb/lbu/sb: one-hot by low2 (00→0001, 01→0010, 10→0100, 11→1000).
  - lh/lhu/sh: 0011 (low2=00) or 1100 (low2=10).
  - lw/sw: 1111.
  - lwl/lwr/swl/swr and none: 0000.
- **SwMode:** 01 for swl, 10 for swr, else 00.
- **WriteData:** m_rt unmodified. The memory takes byte data from [7:0] and halfword data from [15:0].
- **Exceptions:**
  - Out of range: m_addr[31:13] ≠ 0.
  - Misaligned halfword: addr[0] ≠ 0 on lh/lhu/sh.
  - Misaligned word: addr[1:0] ≠ 0 on lw/sw.
  - Unaligned lwl/lwr/swl/swr never raise an exception.
  - Loads raise exc_adel; stores raise exc_ades. Both require m_valid.
- **MemWrite** = m_valid & store op & !exc_ades & !stall & !reset.
- **Load result.** The memory returns the selected byte/half zero-extended in its low bits, and the full word for 1111/0000.
  - lb: sign-extend [7:0]; lbu: zero-extend [7:0].
  - lh: sign-extend [15:0]; lhu: zero-extend [15:0].
  - lw: mem_rdata.
  - lwl by low2 (m = mem_rdata, r = m_rt):
    - 0: {m[7:0], r[23:0]}
    - 1: {m[15:0], r[15:0]}
    - 2: {m[23:0], r[7:0]}
    - 3: m
  - lwr by low2:
    - 0: m
    - 1: {r[31:24], m[31:8]}
    - 2: {r[31:16], m[31:16]}
    - 3: {r[31:8], m[31:24]}
- **W register priority** (checked in this order each clock edge):
  1. reset: w_regwrite, w_dst, w_wdata and store_count all go to 0.
  2. flush: w_regwrite 0, w_dst 0, w_wdata 0.
  3. stall: all W outputs hold.
  4. Otherwise capture: w_regwrite = m_valid & load op & !exc_adel & m_dst ≠ 0; w_dst = m_dst; w_wdata = extended result.
- **store_count:** increments (wrapping at 2^32) on every edge where MemWrite = 1.
- **Non-load in M:** when not stalled, w_regwrite captures 0.

## Timing
- Memory request outputs and exceptions: 0-cycle latency from M inputs.
- Load result: visible on w_* exactly 1 edge after the non-stalled M cycle.
- A store commits exactly once, on its first non-stalled M cycle, even if it was stalled before.
- Simultaneous flush and stall: flush wins.
- Reset mid-store: MemWrite is low during reset and store_count stays 0.

## Test plan
- **Byte loads.** Preload mem[0x10] = 0x88776655.
  - lb @0x13 → ByteEnable 1000; w_wdata 0xFFFFFF88 and w_regwrite 1 one edge later.
  - lbu @0x13 → 0x00000088.
  - lh @0x10 → 0x00006655.
- **lwl/lwr merge.** Same preload, m_rt = 0xAABBCCDD.
  - lwl @0x11 → 0x6655CCDD.
  - lwr @0x12 → 0xAABB8877.
  - lwl @0x13 → 0x88776655.
- **Stores.**
  - sh @0x16, m_rt = 0x1234ABCD → ByteEnable 1100, DataAddr 0x005, WriteData 0x1234ABCD, MemWrite 1; store_count becomes 1.
  - swr @0x11 → SwMode 10, ByteEnable 0000, AddrLow2 01.
- **Exceptions.**
  - lw @0x0E → exc_adel 1, exc_badvaddr 0x0000000E, w_regwrite 0 next cycle.
  - sw @0x00002000 → exc_ades 1, MemWrite 0.
- **Stall.** sb @0x20 held with stall for 3 cycles, then released → MemWrite high only in the release cycle; store_count increments by exactly 1; W outputs frozen during the stall.
- **Priority.**
  - lw valid with flush and stall both high → w_regwrite 0 next edge.
  - reset asserted mid-sequence → all W outputs and store_count 0 on the next edge.
